// File: rtl/rr_dispatcher_if.sv
// Bundle of the dispatcher's upstream stream, per-channel output slots and status.
// The master modport is the dispatcher side. The slave modport is the producer/consumer side.
interface rr_dispatcher_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int CW = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           in_data;
   logic [N-1:0]           out_valid;
   logic [N-1:0]           out_ready;
   logic [N*W-1:0]         out_data;
   logic [$clog2(N)-1:0]   last_sel;
   logic [CW-1:0]          disp_cnt;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, last_sel, disp_cnt
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, last_sel, disp_cnt
   );
endinterface

// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher. One valid/ready input is spread over N one-deep registered slots.
// Each word goes to the first free slot at or above the rotating pointer, or wraps to the lowest free slot.
module rr_dispatcher #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_dispatcher_if.master  bus
);
   localparam int SW = $clog2(N);

   logic [N-1:0]   valid_q;
   logic [N*W-1:0] data_q;
   logic [N-1:0]   ptr_q;
   logic [SW-1:0]  last_q;
   logic [CW-1:0]  cnt_q;

   logic [N-1:0]   free;
   logic [N-1:0]   masked;
   logic [N-1:0]   ptr_nxt;
   logic [SW-1:0]  sel;
   logic           found;
   logic           accept;

   // A slot that is draining this cycle counts as free, so each channel can take one word per cycle.
   always_comb begin
      free    = ~valid_q | bus.out_ready;
      masked  = free & ptr_q;
      sel     = '0;
      found   = 1'b0;
      ptr_nxt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (masked[i] && !found) begin
            sel   = SW'(i);
            found = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (free[i] && !found) begin
            sel   = SW'(i);
            found = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         ptr_nxt[i] = (SW'(i) > sel);
      end
   end

   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.in_ready  = |free;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.last_sel  = last_q;
   assign bus.disp_cnt  = cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         ptr_q   <= '1;
         last_q  <= '0;
         cnt_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (accept && (sel == SW'(i))) begin
               valid_q[i]         <= 1'b1;
               data_q[i*W +: W]   <= bus.in_data;
            end else if (bus.out_ready[i]) begin
               valid_q[i]         <= 1'b0;
            end
         end
         if (accept) begin
            ptr_q  <= ptr_nxt;
            last_q <= sel;
            cnt_q  <= cnt_q + 1'b1;
         end
      end
   end
endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Round-robin distributor: one valid/ready input stream fanned out to N consumer channels. It is the split-side counterpart of the N-to-1 round-robin arbiter.
- Each channel owns a one-deep registered output slot. Every accepted input word goes to the next free channel at or after the rotating priority pointer.
- Sits in front of replicated processing lanes so that load is spread fairly across them.

Parameters:
- N, 4, number of output channels (N >= 2)
- W, 8, data width in bits
- CW, 16, width of the dispatched-word counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  upstream word valid
- in_ready  output  1  dispatcher can accept this cycle (combinational)
- in_data  input  W  upstream word
- out_valid  output  N  per-channel slot valid, registered
- out_ready  input  N  per-channel consumer ready
- out_data  output  N*W  per-channel slot data; channel i occupies bits [i*W +: W], registered
- last_sel  output  $clog2(N)  index of the channel that took the most recent accepted word, registered
- disp_cnt  output  CW  total words accepted since reset, registered

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, last_sel=0, disp_cnt=0.
  - Pointer is all-ones mask, so channel 0 has highest priority.
  - Reset asserted mid-operation discards all held words; no output handshake completes in that cycle.
- Slot i is free when out_valid[i]=0, or when out_valid[i]=1 and out_ready[i]=1 (draining this cycle).
- in_ready = OR of free[i]. Combinational from out_valid and out_ready; no dependence on in_valid.
- Selection, combinational:
  - masked = free & pointer.
  - If masked is nonzero, sel = lowest set bit of masked.
  - Otherwise sel = lowest set bit of free (wrap-around).
- Accept occurs when in_valid & in_ready. At the clk edge:
  - Slot sel loads in_data and out_valid[sel] goes to 1.
  - last_sel <= sel.
  - disp_cnt <= disp_cnt+1, wrapping modulo 2^CW.
  - Pointer <= mask of bits strictly above sel. If sel = N-1 the mask is all-zero, and the next selection wraps to the lowest free channel.
- No accept: pointer, last_sel and disp_cnt hold.
- Channel drain: when out_valid[i] & out_ready[i] and slot i is not loaded this cycle, out_valid[i] goes to 0. out_data[i] holds its last value.
- Simultaneous drain and load on the same channel: new data is loaded and out_valid[i] stays 1. This gives full throughput of one word per cycle per channel.
- Several channels may drain in one cycle. At most one input word is accepted per cycle.
- out_ready[i] with out_valid[i]=0 has no effect.
- Latency: a word accepted at edge k appears on out_valid/out_data after edge k, and is visible from cycle k+1.
- Ordering: words reach the same channel in acceptance order. No ordering is guaranteed across channels.
- Full condition: all slots valid and no out_ready asserted gives in_ready=0, and in_data is ignored.
- Output data on a valid slot must stay stable until that slot's handshake completes.

Test Plan:
- Reset, then in_valid=1 with data 0x10..0x13 on four consecutive cycles, out_ready=4'b0000: channels 0,1,2,3 receive 0x10,0x11,0x12,0x13. After the 4th accept, in_ready=0 and disp_cnt=4. last_sel goes 0,1,2,3.
- Continue from full; assert out_ready=4'b0100 only, with in_data=0x20: in_ready=1, channel 2 reloads 0x20, out_valid stays 4'b1111, disp_cnt=5.
- Wrap: all slots free, pointer after sel=3, in_data=0x30: the word goes to channel 0. Then with channel 1 held full (out_valid[1]=1, out_ready[1]=0), next word 0x31 goes to channel 2 (skips busy channel 1).
- Streaming: out_ready=4'b1111 and in_valid=1 continuously for 8 cycles: channels are hit 0,1,2,3,0,1,2,3, in_ready stays 1, and every slot's value is consumed in the cycle after its load.
- Counter wrap: CW=4, accept 17 words: disp_cnt reads 1 after the 17th.
- Mid-operation reset: two slots valid, rst_n=0 for one edge: out_valid=0, disp_cnt=0. The next accepted word goes to channel 0.
